blink_sequencer: RTL
====================

// Module: blink_sequencer
// PURPOSE
//   Controller that sequences the status-LED datapath: accepts a blink job (bit pattern,
//   per-bit hold time, repeat count) over a valid/ready handshake, then plays it out
//   bit-by-bit on one LED output using an internal prescaler.
//   Sits between the top-level I/O decode (job source) and uo_out[0] (LED pin).
//   Replaces the fixed free-running blink with a software/pin-configurable schedule.
// PARAMETERS
//   PAT_W  8   pattern length in bits (played LSB first); power of two, >=2
//   DIV_W  16  width of per-bit hold divider
//   REP_W  4   width of repeat counter
// PORTS
//   clk          in   1      clock, all logic on rising edge
//   rst          in   1      synchronous reset, active high
//   cfg_valid    in   1      job offered
//   cfg_ready    out  1      block can accept a job (high only in IDLE)
//   cfg_pattern  in   PAT_W  LED level per step, bit 0 first
//   cfg_div      in   DIV_W  hold each bit for cfg_div+1 cycles
//   cfg_repeat   in   REP_W  extra plays of the pattern (0 = play once)
//   abort        in   1      cancel running job
//   led          out  1      LED drive
//   busy         out  1      job in progress
//   done         out  1      one-cycle pulse on normal job completion
//   bit_idx      out  log2(PAT_W)  index of bit currently shown
// BEHAVIOUR
//   - States: IDLE, RUN. Reset (rst=1 at edge): IDLE; busy=0, done=0, led=0, bit_idx=0,
//     cfg_ready=1, prescaler=0, latched pattern/div/repeat=0.
//   - cfg_ready = (state==IDLE). Accept = cfg_valid & cfg_ready at an edge: latch pattern,
//     div, repeat; next cycle state=RUN, busy=1, bit_idx=0, prescaler=0.
//   - led = busy & pat_q[bit_idx]; decoded from registers only, no input-to-led comb path.
//   - RUN: prescaler +1 per cycle; at prescaler==div_q -> step: prescaler<=0, bit_idx+1.
//     div_q=0 -> one cycle per bit. Prescaler never exceeds div_q.
//   - Step at bit_idx==PAT_W-1 (wrap): if reps_left==0 -> IDLE, bit_idx=0, busy=0,
//     done=1 for exactly that cycle; else reps_left-1, bit_idx=0, stay RUN.
//   - Job length from accept edge: (div_q+1)*PAT_W*(repeat_q+1) cycles of busy=1.
//   - cfg_ready is 1 in the done cycle: back-to-back job accept allowed, zero gap.
//   - cfg_valid while busy: ignored, nothing latched, running job unaffected.
//   - abort in RUN: next cycle IDLE, busy=0, led=0, bit_idx=0, no done pulse.
//     abort in IDLE: ignored. abort coincident with final step: abort wins, no done.
//     abort coincident with cfg_valid in IDLE: job accepted (abort ignored in IDLE).
//   - rst mid-RUN: all state to reset values at that edge, no done pulse.
//   - Latched job fields never change during RUN regardless of cfg_* inputs.
// CONFIGURATION
//   BLINK_SEQ_REPEAT_EN defined: cfg_repeat latched and honoured as above.
//   BLINK_SEQ_REPEAT_EN undefined: cfg_repeat ignored (treated as 0), repeat counter
//     not built; every job plays the pattern exactly once. Port list unchanged.
// TESTING
//   1. pattern=8'b1010_0101, div=0, repeat=0 -> led 1,0,1,0,0,1,0,1 on cycles 1..8 after
//      accept; busy 8 cycles; done pulse on cycle 9; cfg_ready=1 on cycle 9.
//   2. pattern=8'h01, div=3 -> led=1 for 4 cycles, 0 for 28; done at cycle 33; bit_idx
//      increments every 4 cycles.
//   3. pattern=8'h0F, div=0, repeat=2 -> macro on: busy 24 cycles, led 1111_0000 x3;
//      macro off: busy 8 cycles, single play.
//   4. pattern=8'hFF, div=9, abort at cycle 15 -> busy=0, led=0 next cycle, done never 1;
//      cfg_valid in IDLE with abort=1 -> new job accepted.
//   5. Start job A (8'hAA), drive cfg_valid with job B (8'h55) at cycle 3 -> B ignored,
//      A completes intact; B offered at done cycle -> accepted back-to-back.
//   6. rst=1 at cycle 5 of a div=0 job -> all outputs reset next edge, no done; new job
//      accepted after rst release plays correctly from bit 0.

Source files
------------

// File: rtl/blink_sequencer.sv
// Blink sequencer: accepts a blink job, then plays its pattern LSB first on one LED.
// Latency: accept edge -> RUN next cycle; job lasts (div+1)*PAT_W*(repeat+1) busy cycles, then a 1-cycle done.
// Backpressure: cfg_ready_o is high only in IDLE (including the done cycle); offers made while busy are dropped.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), synchronous active-high reset
//   cfg_valid_i/_ready_o   job handshake; cfg_pattern_i, cfg_div_i, cfg_repeat_i carry the job
//   abort_i                cancels a running job (ignored in IDLE), no done pulse
//   led_o, busy_o, done_o  LED drive, job-in-progress flag, completion pulse
//   bit_idx_o              index of the pattern bit currently shown
// Optional feature: define BLINK_SEQ_REPEAT_EN to honour cfg_repeat_i; otherwise every
// job plays once and the repeat counter is not built (port list is identical).
module blink_sequencer #(
   parameter int PAT_W = 8,
   parameter int DIV_W = 16,
   parameter int REP_W = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic [PAT_W-1:0]         cfg_pattern_i,
   input  logic [DIV_W-1:0]         cfg_div_i,
   input  logic [REP_W-1:0]         cfg_repeat_i,
   input  logic                     abort_i,
   output logic                     led_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [$clog2(PAT_W)-1:0] bit_idx_o
);

   localparam int IDX_W = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             done_q, done_d;
   logic             last_play;

`ifdef BLINK_SEQ_REPEAT_EN
   logic [REP_W-1:0] reps_q, reps_d;

   // reps_q counts the plays still owed after the current one.
   assign last_play = (reps_q == '0);
`else
   logic unused_repeat;

   assign last_play     = 1'b1;
   assign unused_repeat = ^cfg_repeat_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         div_q   <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
`ifdef BLINK_SEQ_REPEAT_EN
         reps_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         div_q   <= div_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
`ifdef BLINK_SEQ_REPEAT_EN
         reps_q  <= reps_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      div_d   = div_q;
      presc_d = presc_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
`ifdef BLINK_SEQ_REPEAT_EN
      reps_d  = reps_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // abort_i has no effect here, so an abort coinciding with an offer
            // does not block the accept.
            if (cfg_valid_i) begin
               pat_d   = cfg_pattern_i;
               div_d   = cfg_div_i;
`ifdef BLINK_SEQ_REPEAT_EN
               reps_d  = cfg_repeat_i;
`endif
               presc_d = '0;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               // Abort beats a coincident final step: no done pulse.
               state_d = ST_IDLE;
               presc_d = '0;
               idx_d   = '0;
            end else if (presc_q == div_q) begin
               presc_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  if (last_play) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
`ifdef BLINK_SEQ_REPEAT_EN
                  else begin
                     reps_d = reps_q - 1'b1;
                  end
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cfg_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q == ST_RUN);
   // Registered sources only; the stale pattern left after an abort is masked by busy.
   assign led_o       = busy_o & pat_q[idx_q];
   assign done_o      = done_q;
   assign bit_idx_o   = idx_q;

endmodule
